// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/stall controller and the forwarding logic.
package hazard_pkg;

    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        MDU_BUSY  = 2'd2,
        MDU_DONE  = 2'd3
    } hazard_state_e;

endpackage

// File: rtl/hazard_match.sv
// Register dependency compare: EX destination against the ID sources, gated by x0 and the used flags.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic              rs1_used,
    input  logic              rs2_used,
    output logic              match
);

    logic rd_nz;

    always_comb begin
        rd_nz = (rd != '0);
        match = en && rd_nz && ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / MDU / branch hazard controller for the 5-stage pipeline, with a saturating stall counter.
//
// state     | meaning
// IDLE      | normal flow; branch > MDU > load-use evaluated combinationally
// LOAD_WAIT | extra load-use bubble cycles (LOAD_LAT > 1)
// MDU_BUSY  | multi-cycle MDU op holding EX
// MDU_DONE  | last MDU cycle; behaves as IDLE but ignores id_ex_mdu
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_ex_mem_read,
    input  logic [ADDR_W-1:0] id_ex_rd,
    input  logic [ADDR_W-1:0] if_id_rs1,
    input  logic [ADDR_W-1:0] if_id_rs2,
    input  logic              if_id_rs1_used,
    input  logic              if_id_rs2_used,
    input  logic              id_ex_mdu,
    input  logic              ex_branch_taken,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              ex_hold,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int MAX_LAT = (LOAD_LAT > MDU_LAT) ? LOAD_LAT : MDU_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] LOAD_INIT = CW'((LOAD_LAT > 1) ? LOAD_LAT - 1 : 0);
    localparam logic [CW-1:0] MDU_INIT  = CW'((MDU_LAT > 2) ? MDU_LAT - 2 : 0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    hazard_state_e    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             load_use;
    logic             mdu_go;

    hazard_match #(.ADDR_W(ADDR_W)) u_match (
        .en       (id_ex_mem_read),
        .rd       (id_ex_rd),
        .rs1      (if_id_rs1),
        .rs2      (if_id_rs2),
        .rs1_used (if_id_rs1_used),
        .rs2_used (if_id_rs2_used),
        .match    (load_use)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        // MDU_DONE must not re-launch the op still sitting in EX
        mdu_go       = (state_q == IDLE) && id_ex_mdu;

        case (state_q)
            LOAD_WAIT: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                cnt_d        = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) state_d = IDLE;
            end
            MDU_BUSY: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                ex_hold     = 1'b1;
                cnt_d       = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) state_d = MDU_DONE;
            end
            default: begin
                state_d = IDLE;
                if (ex_branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (mdu_go) begin
                    // a single-cycle MDU op still blocks the (illegal) concurrent load-use
                    if (MDU_LAT > 1) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        ex_hold     = 1'b1;
                        if (MDU_LAT > 2) begin
                            state_d = MDU_BUSY;
                            cnt_d   = MDU_INIT;
                        end else begin
                            state_d = MDU_DONE;
                        end
                    end
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = LOAD_WAIT;
                        cnt_d   = LOAD_INIT;
                    end
                end
            end
        endcase

        stall_d = stall_q;
        if (!pc_write && (stall_q != '1)) stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench: two instances (LOAD_LAT=1/MDU_LAT=4/CNT_W=16 and LOAD_LAT=3/MDU_LAT=1/CNT_W=4).
module tb_hazard_stall_unit;

    typedef struct {
        bit         chk;
        logic [5:0] ea;
        logic [5:0] eb;
        int         sa;
        int         sb;
        string      tag;
    } exp_t;

    localparam logic [5:0] N  = 6'b110000;
    localparam logic [5:0] LU = 6'b000100;
    localparam logic [5:0] LW = 6'b000101;
    localparam logic [5:0] M0 = 6'b000010;
    localparam logic [5:0] MB = 6'b000011;
    localparam logic [5:0] MD = 6'b110001;
    localparam logic [5:0] BR = 6'b111100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_read;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, mdu, br;

    logic        pc_a, ifw_a, fl_a, bub_a, hold_a, busy_a;
    logic        pc_b, ifw_b, fl_b, bub_b, hold_b, busy_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   acc_a   = 0;
    int   acc_b   = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.ADDR_W(5), .LOAD_LAT(1), .MDU_LAT(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mem_read), .id_ex_rd(rd),
        .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_rs1_used(u1), .if_id_rs2_used(u2),
        .id_ex_mdu(mdu), .ex_branch_taken(br), .pc_write(pc_a), .if_id_write(ifw_a),
        .if_id_flush(fl_a), .id_ex_bubble(bub_a), .ex_hold(hold_a), .busy(busy_a),
        .stall_cycles(cnt_a)
    );

    hazard_stall_unit #(.ADDR_W(5), .LOAD_LAT(3), .MDU_LAT(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mem_read), .id_ex_rd(rd),
        .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_rs1_used(u1), .if_id_rs2_used(u2),
        .id_ex_mdu(mdu), .ex_branch_taken(br), .pc_write(pc_b), .if_id_write(ifw_b),
        .if_id_flush(fl_b), .id_ex_bubble(bub_b), .ex_hold(hold_b), .busy(busy_b),
        .stall_cycles(cnt_b)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic mr,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic su1, input logic su2, input logic m, input logic b,
                        input logic [5:0] ea, input logic [5:0] eb, input bit chk);
        exp_t e;
        @(posedge clk);
        #2;
        rst_n = rst; mem_read = mr; rd = d; rs1 = s1; rs2 = s2;
        u1 = su1; u2 = su2; mdu = m; br = b;
        e.chk = chk; e.ea = ea; e.eb = eb; e.sa = acc_a; e.sb = acc_b; e.tag = tag;
        exp_q.push_back(e);
        if (!rst) begin
            acc_a = 0;
            acc_b = 0;
        end else begin
            if (!ea[5] && acc_a < 65535) acc_a++;
            if (!eb[5] && acc_b < 15) acc_b++;
        end
    endtask

    task automatic idle(input string tag, input logic [5:0] ea, input logic [5:0] eb);
        step(tag, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb, 1'b1);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.chk) begin
                check_eq({e.tag, " outs_a"}, int'({pc_a, ifw_a, fl_a, bub_a, hold_a, busy_a}), int'(e.ea));
                check_eq({e.tag, " outs_b"}, int'({pc_b, ifw_b, fl_b, bub_b, hold_b, busy_b}), int'(e.eb));
                check_eq({e.tag, " stall_a"}, int'(cnt_a), e.sa);
                check_eq({e.tag, " stall_b"}, int'(cnt_b), e.sb);
            end
        end
    end

    initial begin
        rst_n = 1'b0; mem_read = 1'b0; rd = '0; rs1 = '0; rs2 = '0;
        u1 = 1'b0; u2 = 1'b0; mdu = 1'b0; br = 1'b0;

        step("rst0", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, N, N, 1'b0);
        step("rst1", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, N, N, 1'b0);
        idle("reset_state", N, N);

        step("lu_rs1", 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, LU, LU, 1'b1);
        idle("lu_wait1", N, LW);
        idle("lu_wait2", N, LW);
        idle("lu_done", N, N);

        step("x0_load", 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, N, N, 1'b1);
        step("rs2_unused", 1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, N, N, 1'b1);
        step("lu_rs2", 1'b1, 1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, LU, LU, 1'b1);
        idle("lu_rs2_w1", N, LW);
        idle("lu_rs2_w2", N, LW);

        step("br_lu", 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, BR, BR, 1'b1);
        idle("br_after", N, N);

        step("mdu_go", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, M0, N, 1'b1);
        step("mdu_b1", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MB, N, 1'b1);
        step("mdu_b2", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MB, N, 1'b1);
        step("mdu_done", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MD, N, 1'b1);
        idle("mdu_after", N, N);

        step("rst_go", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, M0, N, 1'b1);
        step("rst_b1", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MB, N, 1'b1);
        step("rst_b2", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MB, N, 1'b1);
        idle("rst_after", N, N);

        for (int i = 0; i < 18; i++) begin
            step("sat_run", 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0,
                 LU, ((i % 3) == 0) ? LU : LW, 1'b1);
        end
        idle("sat_end", N, N);
        idle("sat_hold", N, N);

        repeat (3) @(posedge clk);
        check_eq("scoreboard_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
